// File: rtl/pr_free_list.sv
// pr_free_list: circular FIFO of free physical-register tags feeding rename.
// Optional overflow/underflow sticky flag when PR_FREE_LIST_ERR_EN is defined.
module pr_free_list #(
    parameter  int PR_COUNT       = 128,
    parameter  int ARCH_REG_COUNT = 32,
    parameter  int WIDTH          = 4,
    localparam int LOG_PR_COUNT   = $clog2(PR_COUNT)
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [WIDTH-1:0]              deq_req_mask,
    output logic                          deq_ready,
    output logic [WIDTH*LOG_PR_COUNT-1:0] deq_tag_by_lane,
    input  logic [WIDTH-1:0]              enq_valid_mask,
    input  logic [WIDTH*LOG_PR_COUNT-1:0] enq_tag_by_lane,
    output logic [LOG_PR_COUNT:0]         free_count
`ifdef PR_FREE_LIST_ERR_EN
    ,
    output logic                          err_sticky
`endif
);

    // Pointers wrap by plain overflow, so PR_COUNT must be a power of two.
    localparam int CNT_W   = $clog2(WIDTH + 1);
    localparam int FREE_AT_RESET = PR_COUNT - ARCH_REG_COUNT;

    typedef logic [LOG_PR_COUNT-1:0] tag_t;
    typedef logic [LOG_PR_COUNT:0]   count_t;
    typedef logic [CNT_W-1:0]        pop_t;

    tag_t   entry_q [PR_COUNT];
    tag_t   entry_d [PR_COUNT];
    tag_t   head_q;
    tag_t   head_d;
    tag_t   tail_q;
    tag_t   tail_d;
    count_t count_q;
    count_t count_d;

    pop_t   deq_pop;
    pop_t   enq_push;
    pop_t   deq_pop_eff;
    pop_t   deq_off [WIDTH];
    pop_t   enq_off [WIDTH];
    logic   fire;

    function automatic pop_t popcnt(input logic [WIDTH-1:0] m);
        pop_t c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + pop_t'(m[i]);
        end
        return c;
    endfunction

    // Per-lane compaction offsets: number of active lanes below each lane.
    always_comb begin
        logic [WIDTH-1:0] below;
        for (int i = 0; i < WIDTH; i++) begin
            below      = WIDTH'((32'd1 << i) - 32'd1);
            deq_off[i] = popcnt(deq_req_mask & below);
            enq_off[i] = popcnt(enq_valid_mask & below);
        end
    end

    // Grant decision uses only the registered count; no enqueue bypass.
    always_comb begin
        deq_pop     = popcnt(deq_req_mask);
        enq_push    = popcnt(enq_valid_mask);
        deq_ready   = count_t'(deq_pop) <= count_q;
        fire        = deq_ready & (|deq_req_mask);
        deq_pop_eff = fire ? deq_pop : '0;
    end

    // Same-cycle tag read for each requesting lane from the compacted head.
    always_comb begin
        deq_tag_by_lane = '0;
        for (int i = 0; i < WIDTH; i++) begin
            deq_tag_by_lane[i*LOG_PR_COUNT +: LOG_PR_COUNT] =
                entry_q[head_q + tag_t'(deq_off[i])];
        end
    end

    // Next-state pointers, count and compacted tail writes.
    always_comb begin
        head_d  = head_q + tag_t'(deq_pop_eff);
        tail_d  = tail_q + tag_t'(enq_push);
        count_d = count_q + count_t'(enq_push) - count_t'(deq_pop_eff);
        entry_d = entry_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (enq_valid_mask[i]) begin
                entry_d[tail_q + tag_t'(enq_off[i])] =
                    enq_tag_by_lane[i*LOG_PR_COUNT +: LOG_PR_COUNT];
            end
        end
    end

    // State register; reset loads every non-architectural PR in order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < PR_COUNT; i++) begin
                entry_q[i] <= (i < FREE_AT_RESET) ?
                              tag_t'(ARCH_REG_COUNT + i) : '0;
            end
            head_q  <= '0;
            tail_q  <= tag_t'(FREE_AT_RESET);
            count_q <= count_t'(FREE_AT_RESET);
        end else begin
            entry_q <= entry_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign free_count = count_q;

`ifdef PR_FREE_LIST_ERR_EN
    localparam int SUM_W = LOG_PR_COUNT + 2;

    logic err_q;
    logic err_d;
    logic overflow;
    logic underflow;

    // Sticky error: count would exceed capacity, or a pop exceeds count.
    always_comb begin
        overflow  = (SUM_W'(count_q) + SUM_W'(enq_push)) >
                    (SUM_W'(PR_COUNT) + SUM_W'(deq_pop_eff));
        underflow = fire && (count_q < count_t'(deq_pop));
        err_d     = err_q | overflow | underflow;
    end

    // Error flag register, cleared only by reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_sticky = err_q;
`endif

endmodule
